// File: rtl/serial_par_chk.sv
// Serial frame receiver: DATA_W data bits LSB first, then one parity bit.
// Reports the word, a parity error flag and a saturating error count.
module serial_par_chk #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              par_err,
    output logic [7:0]        err_cnt
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_acc;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_err;
    logic [7:0]        r_errcnt;
    logic              r_busy;
    logic              w_bad;

    assign w_bad     = r_acc ^ bit_in;
    assign busy      = r_busy;
    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign par_err   = r_err;
    assign err_cnt   = r_errcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_acc    <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_errcnt <= 8'd0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // start always (re)opens a frame, aborting any frame in flight
            if (start) begin
                r_state <= DATA;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_shift <= '0;
                r_acc   <= ODD;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_busy <= 1'b0;
                    end
                    DATA: begin
                        if (bit_valid) begin
                            r_shift[r_cnt] <= bit_in;
                            r_acc          <= r_acc ^ bit_in;
                            if (r_cnt == CW'(DATA_W - 1)) begin
                                r_state <= PAR;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    PAR: begin
                        if (bit_valid) begin
                            r_data  <= r_shift;
                            r_err   <= w_bad;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            if (w_bad && (r_errcnt != 8'hFF)) begin
                                r_errcnt <= r_errcnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_par_chk.sv
// Bench for serial_par_chk: a 3-bit even and an 8-bit odd instance
// checked each cycle against a queue-based frame model.
module tb_serial_par_chk;
    logic       clk = 1'b0;
    logic       rst;
    logic       s3, v3, b3, s8, v8, b8;
    logic       bz3, ov3, pe3, bz8, ov8, pe8;
    logic [2:0] do3;
    logic [7:0] do8, ec3, ec8;

    always #5 clk = ~clk;

    serial_par_chk #(.DATA_W(3), .ODD(1'b0)) u3 (
        .clk(clk), .rst(rst), .start(s3), .bit_valid(v3), .bit_in(b3),
        .busy(bz3), .data_out(do3), .out_valid(ov3), .par_err(pe3),
        .err_cnt(ec3)
    );

    serial_par_chk #(.DATA_W(8), .ODD(1'b1)) u8 (
        .clk(clk), .rst(rst), .start(s8), .bit_valid(v8), .bit_in(b8),
        .busy(bz8), .data_out(do8), .out_valid(ov8), .par_err(pe8),
        .err_cnt(ec8)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ov8_n = 0;
    int          mw[2] = '{3, 8};
    bit          mo[2] = '{1'b0, 1'b1};
    bit          m_in[2];
    bit          mq[2][$];
    logic [31:0] m_data[2];
    bit          m_err[2];
    int          m_cnt[2];
    bit          m_ov[2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: collect bits in a queue, judge parity by counting ones.
    task automatic model(int k, bit st, bit v, bit b);
        logic [31:0] d;
        int          ones;
        m_ov[k] = 1'b0;
        if (rst) begin
            m_in[k] = 1'b0;
            mq[k].delete();
            m_data[k] = 0;
            m_err[k] = 1'b0;
            m_cnt[k] = 0;
        end else if (st) begin
            m_in[k] = 1'b1;
            mq[k].delete();
        end else if (m_in[k] && v) begin
            if (mq[k].size() < mw[k]) begin
                mq[k].push_back(b);
            end else begin
                d = 0;
                ones = int'(b);
                for (int i = 0; i < mw[k]; i++) begin
                    d[i] = mq[k][i];
                    ones += int'(mq[k][i]);
                end
                m_data[k] = d;
                m_err[k] = ((ones % 2) != int'(mo[k]));
                if (m_err[k] && m_cnt[k] < 255) m_cnt[k]++;
                m_ov[k] = 1'b1;
                m_in[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model(0, s3, v3, b3);
        model(1, s8, v8, b8);
        #1;
        if (ov8 === 1'b1) ov8_n++;
        chk("m3_ov", ov3, m_ov[0]);
        chk("m3_busy", bz3, m_in[0]);
        chk("m3_data", do3, m_data[0]);
        chk("m3_err", pe3, m_err[0]);
        chk("m3_cnt", ec3, m_cnt[0]);
        chk("m8_ov", ov8, m_ov[1]);
        chk("m8_busy", bz8, m_in[1]);
        chk("m8_data", do8, m_data[1]);
        chk("m8_err", pe8, m_err[1]);
        chk("m8_cnt", ec8, m_cnt[1]);
    endtask

    task automatic send3(bit st, bit v, bit b);
        rst = 1'b0;
        s3 = st; v3 = v; b3 = b;
        s8 = 1'b0; v8 = 1'b0; b8 = 1'b0;
        tick();
    endtask

    task automatic send8(bit st, bit v, bit b);
        rst = 1'b0;
        s8 = st; v8 = v; b8 = b;
        s3 = 1'b0; v3 = 1'b0; b3 = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s3 = 1'b0; v3 = 1'b0; b3 = 1'b0;
        s8 = 1'b0; v8 = 1'b0; b8 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Ends with the parity bit sampled, i.e. in the out_valid cycle.
    task automatic frame8(logic [7:0] d, bit p, int gap, bit chk_busy);
        send8(1'b1, 1'b0, 1'b0);
        if (chk_busy) chk("busy_start", bz8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            repeat (gap) begin
                send8(1'b0, 1'b0, 1'b0);
                if (chk_busy) chk("busy_gap", bz8, 1'b1);
            end
            send8(1'b0, 1'b1, d[i]);
            if (chk_busy) chk("busy_bit", bz8, 1'b1);
        end
        repeat (gap) send8(1'b0, 1'b0, 1'b0);
        send8(1'b0, 1'b1, p);
    endtask

    typedef struct {
        bit       st;
        bit       v;
        bit       b;
        bit       ov;
        bit       bz;
        bit [2:0] d;
        bit       pe;
        int       ec;
    } vec_t;

    vec_t tbl[$];
    int   ov_before;

    initial begin
        // st v b | ov busy data err cnt  (state after the edge)
        tbl.push_back(vec_t'{1, 1, 1, 0, 1, 3'd0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 1, 3'd0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 1, 3'd0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 1, 0, 3'd3, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 3'd3, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0, 1, 3'd3, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd3, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 1, 3'd3, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd3, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 0, 3'd5, 1, 1});
        tbl.push_back(vec_t'{1, 0, 0, 0, 1, 3'd5, 1, 1});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd5, 1, 1});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd5, 1, 1});
        tbl.push_back(vec_t'{0, 1, 1, 0, 1, 3'd5, 1, 1});
        tbl.push_back(vec_t'{0, 1, 1, 1, 0, 3'd7, 0, 1});
        tbl.push_back(vec_t'{0, 1, 1, 0, 0, 3'd7, 0, 1});

        rst = 1'b1;
        s3 = 1'b0; v3 = 1'b0; b3 = 1'b0;
        s8 = 1'b0; v8 = 1'b0; b8 = 1'b0;
        tick();
        do_reset();
        chk("rst_busy", bz8, 1'b0);
        chk("rst_data", do8, 8'h00);
        chk("rst_ov", ov8, 1'b0);
        chk("rst_cnt", ec3, 8'd0);

        foreach (tbl[i]) begin
            send3(tbl[i].st, tbl[i].v, tbl[i].b);
            chk($sformatf("t%0d_ov", i), ov3, tbl[i].ov);
            chk($sformatf("t%0d_busy", i), bz3, tbl[i].bz);
            chk($sformatf("t%0d_data", i), do3, tbl[i].d);
            chk($sformatf("t%0d_err", i), pe3, tbl[i].pe);
            chk($sformatf("t%0d_cnt", i), ec3, tbl[i].ec);
        end

        // A5 with gapped bits, odd parity bit 1 is correct
        frame8(8'hA5, 1'b1, 2, 1'b1);
        chk("a5_ov", ov8, 1'b1);
        chk("a5_data", do8, 8'hA5);
        chk("a5_err", pe8, 1'b0);
        chk("a5_busy", bz8, 1'b0);
        send8(1'b0, 1'b0, 1'b0);
        chk("a5_ov_once", ov8, 1'b0);
        chk("a5_hold", do8, 8'hA5);

        // abort after two bits, then a full 3C frame
        ov_before = ov8_n;
        send8(1'b1, 1'b0, 1'b0);
        send8(1'b0, 1'b1, 1'b1);
        send8(1'b0, 1'b1, 1'b1);
        frame8(8'h3C, 1'b1, 0, 1'b0);
        repeat (3) send8(1'b0, 1'b0, 1'b0);
        chk("abort_ov_count", ov8_n - ov_before, 1);
        chk("abort_data", do8, 8'h3C);
        chk("abort_err", pe8, 1'b0);

        // error counter saturation on the 3-bit instance
        do_reset();
        for (int f = 1; f <= 256; f++) begin
            send3(1'b1, 1'b0, 1'b0);
            repeat (3) send3(1'b0, 1'b1, 1'b0);
            send3(1'b0, 1'b1, 1'b1);
            if (f == 254) chk("sat254", ec3, 8'd254);
            if (f == 255) chk("sat255", ec3, 8'd255);
            if (f == 256) chk("sat256", ec3, 8'd255);
        end
        do_reset();
        chk("sat_rst_cnt", ec3, 8'd0);
        chk("sat_rst_data", do3, 3'd0);
        chk("sat_rst_busy", bz3, 1'b0);

        // reset mid-frame, with start/valid asserted alongside it
        ov_before = ov8_n;
        send8(1'b1, 1'b0, 1'b0);
        repeat (5) send8(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        s8 = 1'b1; v8 = 1'b1; b8 = 1'b1;
        tick();
        chk("mid_rst_busy", bz8, 1'b0);
        repeat (12) send8(1'b0, 1'b1, 1'b1);
        chk("mid_rst_no_ov", ov8_n - ov_before, 0);
        chk("mid_rst_idle", bz8, 1'b0);

        // random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            s3 = ($urandom_range(0, 19) == 0);
            v3 = $urandom_range(0, 1) == 1;
            b3 = $urandom_range(0, 1) == 1;
            s8 = ($urandom_range(0, 29) == 0);
            v8 = $urandom_range(0, 2) != 0;
            b8 = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_par_chk.md
SERIAL_PAR_CHK -- requirements
Module: serial_par_chk

Interface
- REQ-001: Parameter DATA_W, default 8, number of data bits per frame; legal range 2..32.
- REQ-002: Parameter ODD, default 0, parity sense: 0 = even parity (XOR of data and parity bits = 0), 1 = odd parity (XOR = 1).
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: start  input  1  single-cycle pulse marking the beginning of a frame.
- REQ-006: bit_valid  input  1  qualifies bit_in for the current cycle.
- REQ-007: bit_in  input  1  serial data/parity bit; LSB first, parity bit last.
- REQ-008: busy  output  1  high while a frame is in progress.
- REQ-009: data_out  output  DATA_W  received data word, held stable between frames.
- REQ-010: out_valid  output  1  one-cycle pulse; data_out and par_err are valid for that cycle.
- REQ-011: par_err  output  1  parity mismatch flag for the completed frame, held until the next completion.
- REQ-012: err_cnt  output  8  count of frames with a parity error, saturating.

Function
- REQ-013: The FSM has exactly three states: IDLE, DATA, PAR.
- REQ-014: IDLE -> DATA on start=1; bit counter cleared; the running parity accumulator is loaded with ODD.
- REQ-015: bit_valid during the start cycle is ignored; the first data bit is accepted no earlier than the cycle after start.
- REQ-016: In DATA, each cycle with bit_valid=1 shifts bit_in into the shift register at position bit_count (LSB first), XORs it into the accumulator, and increments bit_count.
- REQ-017: Cycles with bit_valid=0 in DATA or PAR hold all state; there is no timeout.
- REQ-018: DATA -> PAR when the DATA_W-th data bit is accepted.
- REQ-019: In PAR, the first cycle with bit_valid=1 is the parity bit.
  - On that edge: data_out is loaded with the shift register.
  - par_err is set to (accumulator XOR bit_in).
  - out_valid=1 for the following cycle only.
  - The FSM returns to IDLE.
- REQ-020: Latency: out_valid is asserted in the cycle immediately after the parity bit is sampled.
- REQ-021: err_cnt increments by 1 on each completion with par_err=1 and saturates at 255 (no wrap).
- REQ-022: busy = 1 in DATA and PAR, 0 in IDLE; it is registered from state.
- REQ-023: start=1 while in DATA or PAR aborts the current frame.
  - No out_valid is produced.
  - data_out, par_err and err_cnt are unchanged.
  - A new frame begins exactly as in REQ-014.
- REQ-024: bit_valid=1 in IDLE with start=0 is ignored; no state change.
- REQ-025: A start arriving in the cycle where out_valid=1 (FSM already in IDLE) begins a new frame normally; the completed result is unaffected.

Reset
- REQ-026: While rst=1, on each clock edge:
  - state = IDLE; bit_count = 0; shift register = 0; accumulator = 0.
  - data_out = 0; out_valid = 0; par_err = 0; err_cnt = 0; busy = 0.
- REQ-027: rst takes precedence over start and bit_valid in the same cycle.
- REQ-028: rst asserted mid-frame discards the frame with no out_valid.
- REQ-029: After rst deasserts, the block waits in IDLE for start.

Verification
- REQ-030: DATA_W=3, ODD=0; start, then bits 1,1,0 (data 3'b011), then parity 0 -> out_valid one cycle after parity; data_out=3'b011, par_err=0, err_cnt=0.
- REQ-031: DATA_W=3, ODD=0; data 3'b101 with parity 1 -> data_out=3'b101, par_err=1, err_cnt=1. Then a correct frame 3'b111 with parity 1 -> par_err=0, err_cnt stays 1.
- REQ-032: DATA_W=8, ODD=1; data 8'hA5 with bit_valid gapped (idle cycles between bits), parity 1 -> data_out=8'hA5, par_err=0, busy high from the cycle after start until the cycle of out_valid.
- REQ-033: start after 2 data bits, then a full valid frame 8'h3C -> exactly one out_valid, data_out=8'h3C; no output from the aborted frame.
- REQ-034: 256 consecutive bad-parity frames -> err_cnt=255 after the 255th frame and stays 255; rst then forces err_cnt=0, data_out=0, busy=0.
- REQ-035: rst pulsed after 5 of 8 data bits, then bit_valid pulses without start -> no out_valid, busy=0, state stays IDLE.
